button_step_debouncer: RTL

BUTTON_STEP_DEBOUNCER -- requirements
Module: button_step_debouncer

---
 rtl/button_step_debouncer.sv | 106 ++++++++++
 1 files changed

// File: rtl/button_step_debouncer.sv
// Push-button debouncer: synchronizes a noisy raw button level, qualifies each
// level change over STABLE_CYCLES consecutive synchronized samples, and emits
// one registered step pulse per accepted press for the downstream counter chain.
//
// state        | meaning
// -------------+---------------------------------------------------------
// RELEASED     | debounced level is 0, waiting for a synchronized 1
// PRESS_WAIT   | saw a 1, counting stable 1 samples before accepting press
// PRESSED      | debounced level is 1, waiting for a synchronized 0
// RELEASE_WAIT | saw a 0, counting stable 0 samples before accepting release

module button_step_debouncer #(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic button_raw,
   output logic step_pulse,
   output logic button_state
);

   localparam int unsigned CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] stable_cnt;
   logic             sync_1;
   logic             sync_2;

   // Two-flop synchronizer; only sync_2 is seen by the state machine.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= button_raw;
         sync_2 <= sync_1;
      end
   end

   // Qualification FSM with stability counter and registered outputs.
   // The counter never wraps: each wait state leaves when it reaches CNT_LAST.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= RELEASED;
         stable_cnt   <= '0;
         step_pulse   <= 1'b0;
         button_state <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (sync_2) begin
                  state      <= PRESS_WAIT;
                  stable_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync_2) begin
                  state      <= RELEASED;
                  stable_cnt <= '0;
               end else if (stable_cnt == CNT_LAST) begin
                  state        <= PRESSED;
                  stable_cnt   <= '0;
                  button_state <= 1'b1;
                  step_pulse   <= 1'b1;
               end else begin
                  stable_cnt <= stable_cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!sync_2) begin
                  state      <= RELEASE_WAIT;
                  stable_cnt <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (sync_2) begin
                  // bounce back to pressed: no new pulse, the press was already counted
                  state      <= PRESSED;
                  stable_cnt <= '0;
               end else if (stable_cnt == CNT_LAST) begin
                  state        <= RELEASED;
                  stable_cnt   <= '0;
                  button_state <= 1'b0;
               end else begin
                  stable_cnt <= stable_cnt + CNT_ONE;
               end
            end
            default: begin
               state      <= RELEASED;
               stable_cnt <= '0;
            end
         endcase
      end
   end

endmodule
